// File: rtl/adc_view_sequencer.sv
// View sequencer for the ADC display path: steps mode/source from buttons or an
// auto-scan timer, blanks for a settle window, then captures the muxed value.
module adc_view_sequencer #(
  parameter int SCAN_CYCLES   = 100_000_000,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mode_step,
  input  logic        src_step,
  input  logic        auto_en,
  input  logic        hold,
  input  logic [15:0] value_in,
  output logic [1:0]  display_mode,
  output logic [1:0]  adc_sel,
  output logic [15:0] disp_value,
  output logic        blank,
  output logic        view_changed
);

  localparam int SCAN_W   = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_SHOW   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [1:0]          src_q, src_d;
  logic [15:0]         disp_q, disp_d;
  logic                blank_q, blank_d;
  logic                vc_q, vc_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic                manual_step;
  logic                auto_tick;
  logic                view_change;

  // Both mode and source count modulo 3; code 3 can never be produced.
  function automatic logic [1:0] wrap3(input logic [1:0] v);
    return (v >= 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    src_d        = src_q;
    disp_d       = disp_q;
    blank_d      = blank_q;
    vc_d         = 1'b0;
    settle_cnt_d = settle_cnt_q;
    scan_cnt_d   = scan_cnt_q;

    manual_step = (mode_step | src_step) & ~hold;
    auto_tick   = (state_q == ST_SHOW) & auto_en & ~hold & (scan_cnt_q == SCAN_LAST);
    view_change = manual_step | auto_tick;

    if ((state_q == ST_SHOW) && !hold) begin
      disp_d = value_in;
    end

    // A manual step pre-empts a coincident auto tick.
    if (manual_step) begin
      if (mode_step) mode_d = wrap3(mode_q);
      if (src_step)  src_d  = wrap3(src_q);
    end else if (auto_tick) begin
      src_d = wrap3(src_q);
      if (src_q == 2'd2) mode_d = wrap3(mode_q);
    end

    if (view_change) begin
      vc_d         = 1'b1;
      state_d      = ST_SETTLE;
      blank_d      = 1'b1;
      settle_cnt_d = '0;
      scan_cnt_d   = '0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          blank_d = 1'b1;
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d      = ST_SHOW;
            blank_d      = 1'b0;
            settle_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
        default: begin
          blank_d = 1'b0;
        end
      endcase

      if (!auto_en) begin
        scan_cnt_d = '0;
      end else if (!hold && (state_q == ST_SHOW)) begin
        scan_cnt_d = scan_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_SETTLE;
      mode_q       <= 2'd0;
      src_q        <= 2'd0;
      disp_q       <= 16'd0;
      blank_q      <= 1'b1;
      vc_q         <= 1'b0;
      settle_cnt_q <= '0;
      scan_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      src_q        <= src_d;
      disp_q       <= disp_d;
      blank_q      <= blank_d;
      vc_q         <= vc_d;
      settle_cnt_q <= settle_cnt_d;
      scan_cnt_q   <= scan_cnt_d;
    end
  end

  assign display_mode = mode_q;
  assign adc_sel      = src_q;
  assign disp_value   = disp_q;
  assign blank        = blank_q;
  assign view_changed = vc_q;

endmodule

// File: tb/tb_adc_view_sequencer.sv
// Bench for adc_view_sequencer: a view-age/dwell model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_adc_view_sequencer;

  localparam int SCAN   = 8;
  localparam int SETTLE = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mode_step = 1'b0;
  logic        src_step = 1'b0;
  logic        auto_en = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] value_in = 16'h0ABC;
  logic [1:0]  display_mode;
  logic [1:0]  adc_sel;
  logic [15:0] disp_value;
  logic        blank;
  logic        view_changed;

  int n_assert = 0;
  int n_fail   = 0;
  int vc_count = 0;

  adc_view_sequencer #(
    .SCAN_CYCLES  (SCAN),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mode_step   (mode_step),
    .src_step    (src_step),
    .auto_en     (auto_en),
    .hold        (hold),
    .value_in    (value_in),
    .display_mode(display_mode),
    .adc_sel     (adc_sel),
    .disp_value  (disp_value),
    .blank       (blank),
    .view_changed(view_changed)
  );

  always #5 clk = ~clk;

  // Model: the view is (mode, src); m_age counts edges since the last view
  // change (saturating at SETTLE), so the display is blanked while m_age < SETTLE.
  int   m_mode, m_src, m_age, m_dwell;
  logic [15:0] m_disp;
  logic m_vc;

  always @(posedge clk or negedge reset_n) begin
    bit showing, manual, tick;
    if (!reset_n) begin
      m_mode  <= 0;
      m_src   <= 0;
      m_age   <= 0;
      m_dwell <= 0;
      m_disp  <= 16'h0;
      m_vc    <= 1'b0;
    end else begin
      showing = (m_age >= SETTLE);
      manual  = (mode_step || src_step) && !hold;
      tick    = showing && auto_en && !hold && (m_dwell == SCAN - 1);
      if (showing && !hold) m_disp <= value_in;
      m_vc <= manual || tick;
      if (manual) begin
        if (mode_step) m_mode <= (m_mode + 1) % 3;
        if (src_step)  m_src  <= (m_src + 1) % 3;
      end else if (tick) begin
        m_src <= (m_src + 1) % 3;
        if (m_src == 2) m_mode <= (m_mode + 1) % 3;
      end
      if (manual || tick) begin
        m_age   <= 0;
        m_dwell <= 0;
      end else begin
        m_age <= (m_age < SETTLE) ? m_age + 1 : SETTLE;
        if (!auto_en)              m_dwell <= 0;
        else if (showing && !hold) m_dwell <= m_dwell + 1;
      end
    end
  end

  task automatic chk(input string name, input int actual, input int expected);
    n_assert++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_mode",  int'(display_mode), m_mode);
    chk("cyc_src",   int'(adc_sel), m_src);
    chk("cyc_disp",  int'(disp_value), int'(m_disp));
    chk("cyc_blank", int'(blank), (m_age < SETTLE) ? 1 : 0);
    chk("cyc_vc",    int'(view_changed), int'(m_vc));
    if (view_changed) vc_count <= vc_count + 1;
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Waits for the next view_changed pulse; returns edges elapsed, bounded.
  task automatic wait_vc(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!view_changed && n < 40);
    if (!view_changed) begin
      n_assert++;
      n_fail++;
      $display("FAIL wait_vc: no view_changed within 40 cycles at %0t", $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mode"},  int'(display_mode), 0);
    chk({tag, "_src"},   int'(adc_sel), 0);
    chk({tag, "_disp"},  int'(disp_value), 0);
    chk({tag, "_blank"}, int'(blank), 1);
    chk({tag, "_vc"},    int'(view_changed), 0);
  endtask

  int n;
  int vc_base;
  int exp_mode[9] = '{0, 0, 1, 1, 1, 2, 2, 2, 0};
  int exp_src[9]  = '{1, 2, 0, 1, 2, 0, 1, 2, 0};
  int mode_seq[4] = '{1, 2, 0, 1};

  initial begin
    // Reset and first capture
    steps(2);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    steps(2);
    chk("rel_blank2", int'(blank), 1);
    step();
    chk("rel_blank3", int'(blank), 0);
    chk("rel_nocap", int'(disp_value), 0);
    step();
    chk("rel_cap", int'(disp_value), 16'h0ABC);
    steps(3);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async");
    step();
    reset_n = 1'b1;
    steps(5);

    // Source wrap
    vc_base = vc_count;
    for (int i = 0; i < 3; i++) begin
      src_step = 1'b1;
      step();
      src_step = 1'b0;
      chk("src_wrap", int'(adc_sel), (i + 1) % 3);
      chk("src_mode", int'(display_mode), 0);
      chk("src_blank", int'(blank), 1);
      steps(9);
    end
    chk("src_vc_count", vc_count - vc_base, 3);

    // Mode wrap
    for (int i = 0; i < 4; i++) begin
      mode_step = 1'b1;
      step();
      mode_step = 1'b0;
      chk("mode_wrap", int'(display_mode), mode_seq[i]);
      steps(6);
    end
    for (int i = 0; i < 2; i++) begin
      mode_step = 1'b1;
      step();
      mode_step = 1'b0;
      steps(6);
    end
    chk("mode_back0", int'(display_mode), 0);

    // Simultaneous steps
    vc_base = vc_count;
    mode_step = 1'b1;
    src_step  = 1'b1;
    step();
    mode_step = 1'b0;
    src_step  = 1'b0;
    chk("both_mode", int'(display_mode), 1);
    chk("both_src", int'(adc_sel), 1);
    steps(6);
    chk("both_vc_count", vc_count - vc_base, 1);

    // Auto-scan from a clean reset
    reset_n = 1'b0;
    auto_en = 1'b1;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_vc(n);
      chk("auto_period", n, SETTLE + SCAN);
      chk("auto_mode", int'(display_mode), exp_mode[i]);
      chk("auto_src", int'(adc_sel), exp_src[i]);
    end
    wait_vc(n);
    wait_vc(n);
    chk("auto_pre_src", int'(adc_sel), 2);
    steps(SETTLE + SCAN - 1);
    src_step = 1'b1;
    step();
    src_step = 1'b0;
    chk("inject_vc", int'(view_changed), 1);
    chk("inject_mode", int'(display_mode), 0);
    chk("inject_src", int'(adc_sel), 0);
    wait_vc(n);
    chk("inject_next", n, SETTLE + SCAN);
    chk("inject_next_src", int'(adc_sel), 1);
    auto_en = 1'b0;

    // Hold during SHOW
    value_in = 16'h1234;
    steps(5);
    chk("hold_pre_blank", int'(blank), 0);
    chk("hold_pre_disp", int'(disp_value), 16'h1234);
    hold = 1'b1;
    step();
    value_in = 16'h5678;
    vc_base  = vc_count;
    src_step = 1'b1;
    step();
    src_step = 1'b0;
    steps(3);
    chk("hold_disp", int'(disp_value), 16'h1234);
    chk("hold_src", int'(adc_sel), 1);
    chk("hold_no_vc", vc_count - vc_base, 0);
    hold = 1'b0;
    step();
    chk("unhold_disp", int'(disp_value), 16'h5678);

    // Hold during SETTLE
    src_step = 1'b1;
    step();
    src_step = 1'b0;
    hold     = 1'b1;
    value_in = 16'h9999;
    chk("hs_src", int'(adc_sel), 2);
    chk("hs_blank0", int'(blank), 1);
    steps(2);
    chk("hs_blank2", int'(blank), 1);
    step();
    chk("hs_unblank", int'(blank), 0);
    steps(3);
    chk("hs_frozen", int'(disp_value), 16'h5678);
    hold = 1'b0;
    step();
    chk("hs_capture", int'(disp_value), 16'h9999);
    steps(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
